// File: rtl/rng_addr_pkg.sv
// Shared types and helpers for the RNG address selector: FSM states, mode codes
// and the power-of-two mask used by rejection sampling.
package rng_addr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MODE_MODULO = 0;
    localparam int MODE_REJECT = 1;

    // Widest count the mask helper supports.
    localparam int MASK_W = 64;

    // Smallest 2^k >= count, minus one (count 0 and 1 both give 0).
    function automatic logic [MASK_W-1:0] pow2_mask(input logic [MASK_W-1:0] count);
        logic [MASK_W-1:0] m;
        if (count == '0) begin
            m = '0;
        end else begin
            m = count - MASK_W'(1);
            for (int s = 1; s < MASK_W; s = s * 2) begin
                m = m | (m >> s);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_mod_reduce.sv
// Restoring shift-subtract remainder of din by divisor, MSB first, one bit per cycle.
// Latency RNG_W cycles after load; valid flags the final step and result is combinational that cycle.
module seq_mod_reduce #(
    parameter int CNT_W = 16,
    parameter int RNG_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [RNG_W-1:0] din,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] result
);

    localparam int BIT_W = $clog2(RNG_W + 1);

    logic [RNG_W-1:0] shreg;
    logic [CNT_W-1:0] rem;
    logic [CNT_W:0]   trial;
    logic [CNT_W-1:0] rem_step;
    logic [BIT_W-1:0] bits_left;

    // rem stays below divisor between steps, so the shifted trial fits in CNT_W+1 bits.
    always_comb begin
        trial = {rem, shreg[RNG_W-1]};
        if (trial >= {1'b0, divisor}) begin
            rem_step = CNT_W'(trial - {1'b0, divisor});
        end else begin
            rem_step = trial[CNT_W-1:0];
        end
    end

    assign busy   = (bits_left != '0);
    assign valid  = (bits_left == BIT_W'(1));
    assign result = rem_step;

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg     <= '0;
            rem       <= '0;
            bits_left <= '0;
        end else if (load) begin
            shreg     <= din;
            rem       <= '0;
            bits_left <= BIT_W'(RNG_W);
        end else if (busy) begin
            shreg     <= shreg << 1;
            rem       <= rem_step;
            bits_left <= bits_left - BIT_W'(1);
        end
    end

endmodule

// File: rtl/rng_address_sel.sv
// Picks an index in [0, count) from RNG words by modulo reduction or rejection sampling with modulo fallback.
// Latency 1 cycle for count<=1, RNG_W+2 for modulo, 2 for a first-draw accept; stalls in DRAW while rng_valid is low.
module rng_address_sel
    import rng_addr_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int RNG_W     = 16,
    parameter int MODE      = 0,
    parameter int MAX_TRIES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [RNG_W-1:0] rng_in,
    input  logic             rng_valid,
    output logic             rng_ready,
    output logic [CNT_W-1:0] addr_out,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    if (RNG_W < CNT_W) begin : g_bad_rng_w
        $error("rng_address_sel: RNG_W (%0d) must be >= CNT_W (%0d)", RNG_W, CNT_W);
    end
    if (CNT_W > MASK_W || CNT_W < 1) begin : g_bad_cnt_w
        $error("rng_address_sel: CNT_W (%0d) out of range", CNT_W);
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("rng_address_sel: MAX_TRIES (%0d) must be >= 1", MAX_TRIES);
    end
    if (MODE != MODE_MODULO && MODE != MODE_REJECT) begin : g_bad_mode
        $error("rng_address_sel: MODE (%0d) must be 0 or 1", MODE);
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] mask_q;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_inc;
    logic [CNT_W-1:0] masked;
    logic             hit;
    logic             give_up;
    logic             start_ok;
    logic             red_load;
    logic             red_busy;
    logic             red_valid;
    logic [CNT_W-1:0] red_result;

    assign masked    = rng_in[CNT_W-1:0] & mask_q;
    assign hit       = (masked < cnt_q);
    assign tries_inc = tries + TRY_W'(1);
    assign give_up   = (tries_inc == TRY_W'(MAX_TRIES));

    assign rng_ready = (state == DRAW);
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        red_load   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (count <= CNT_W'(1)) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (rng_valid) begin
                    if (MODE == MODE_MODULO) begin
                        red_load   = 1'b1;
                        state_next = REDUCE;
                    end else if (hit) begin
                        state_next = DONE;
                    end else if (give_up) begin
                        red_load   = 1'b1;
                        state_next = REDUCE;
                    end
                end
            end
            REDUCE: begin
                // An idle reducer here would mean a lost load; leave rather than hang.
                if (red_valid || !red_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            mask_q   <= '0;
            tries    <= '0;
            addr_out <= '0;
            err      <= 1'b0;
        end else begin
            if (start_ok) begin
                cnt_q    <= count;
                mask_q   <= CNT_W'(pow2_mask(MASK_W'(count)));
                tries    <= '0;
                addr_out <= '0;
                err      <= (count == '0);
            end
            if (state == DRAW && rng_valid && MODE == MODE_REJECT) begin
                if (hit) begin
                    addr_out <= masked;
                end else begin
                    tries <= tries_inc;
                end
            end
            if (state == REDUCE && red_valid) begin
                addr_out <= red_result;
            end
        end
    end

    seq_mod_reduce #(
        .CNT_W(CNT_W),
        .RNG_W(RNG_W)
    ) u_reduce (
        .clock  (clock),
        .reset  (reset),
        .load   (red_load),
        .din    (rng_in),
        .divisor(cnt_q),
        .busy   (red_busy),
        .valid  (red_valid),
        .result (red_result)
    );

endmodule

// File: tb/tb_rng_address_sel.sv
// Scoreboard bench: a modulo instance and a rejection instance driven with random RNG streams,
// expectations from a plain-arithmetic model, checked by a monitor on every done pulse.
module tb_rng_address_sel;

    localparam int CNT_W     = 16;
    localparam int RNG_W     = 16;
    localparam int MAX_TRIES = 8;
    localparam int LIMIT     = 400;

    typedef struct {
        logic [15:0] addr;
        logic        err;
        int          xfers;
        int          lat;
        int          cnt;
        int          st;
        int          xbase;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset;
    logic [1:0]       start_v, rng_valid_v, rng_ready_v, done_v, busy_v, err_v;
    logic [1:0][15:0] count_v, rng_in_v, addr_out_v;

    rng_address_sel #(.CNT_W(CNT_W), .RNG_W(RNG_W), .MODE(0), .MAX_TRIES(MAX_TRIES)) dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .count(count_v[0]),
        .rng_in(rng_in_v[0]), .rng_valid(rng_valid_v[0]), .rng_ready(rng_ready_v[0]),
        .addr_out(addr_out_v[0]), .done(done_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    rng_address_sel #(.CNT_W(CNT_W), .RNG_W(RNG_W), .MODE(1), .MAX_TRIES(MAX_TRIES)) dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .count(count_v[1]),
        .rng_in(rng_in_v[1]), .rng_valid(rng_valid_v[1]), .rng_ready(rng_ready_v[1]),
        .addr_out(addr_out_v[1]), .done(done_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int xfer_total [2];
    int done_cnt [2];
    exp_t sb0[$];
    exp_t sb1[$];
    logic [15:0] words [MAX_TRIES];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Expected result from the selection rules, using plain integer arithmetic.
    task automatic model(input int d, input logic [15:0] c, output exp_t e);
        int p;
        bit found;
        e.addr = 16'd0; e.err = (c == 16'd0); e.xfers = 0; e.lat = 1;
        e.cnt = int'(c); e.st = 0; e.xbase = 0;
        if (c >= 16'd2) begin
            if (d == 0) begin
                e.addr = 16'(int'(words[0]) % int'(c));
                e.xfers = 1;
                e.lat = RNG_W + 2;
            end else begin
                p = 1;
                while (p < int'(c)) p = p * 2;
                found = 1'b0;
                for (int j = 0; j < MAX_TRIES; j++) begin
                    if (!found && ((int'(words[j]) & (p - 1)) < int'(c))) begin
                        found = 1'b1;
                        e.addr = 16'(int'(words[j]) & (p - 1));
                        e.xfers = j + 1;
                        e.lat = j + 2;
                    end
                end
                if (!found) begin
                    e.addr = 16'(int'(words[MAX_TRIES-1]) % int'(c));
                    e.xfers = MAX_TRIES;
                    e.lat = MAX_TRIES + RNG_W + 1;
                end
            end
        end
    endtask

    task automatic compare(input int d, input exp_t e);
        check($sformatf("addr_out[dut%0d cnt=%0d]", d, e.cnt), int'(addr_out_v[d]), int'(e.addr));
        check($sformatf("err[dut%0d cnt=%0d]", d, e.cnt), int'(err_v[d]), int'(e.err));
        check($sformatf("rng_transfers[dut%0d cnt=%0d]", d, e.cnt), xfer_total[d] - e.xbase, e.xfers);
        check($sformatf("busy_in_done[dut%0d]", d), int'(busy_v[d]), 1);
        if (e.lat >= 0) check($sformatf("latency[dut%0d cnt=%0d]", d, e.cnt), cyc - e.st, e.lat);
        if (!e.err) check($sformatf("addr_below_count[dut%0d]", d), int'(addr_out_v[d] < e.cnt[15:0]), 1);
    endtask

    // Monitor: counts RNG handshakes and checks each done pulse against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            sb0.delete();
            sb1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (rng_valid_v[d] && rng_ready_v[d]) xfer_total[d]++;
            end
            if (done_v[0]) begin
                if (sb0.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done dut0: done=1 with no request outstanding (cycle %0d)", cyc);
                end else compare(0, sb0.pop_front());
                done_cnt[0]++;
            end
            if (done_v[1]) begin
                if (sb1.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done dut1: done=1 with no request outstanding (cycle %0d)", cyc);
                end else compare(1, sb1.pop_front());
                done_cnt[1]++;
            end
        end
    end

    task automatic run(input int d, input logic [15:0] c, input bit hold, input bit stress, input int gap);
        exp_t e;
        int idx, n0, k;
        bit took, saw_ready;
        model(d, c, e);
        if (!(hold && gap == 0)) e.lat = -1;
        @(posedge clock); #1;
        e.st = cyc;
        e.xbase = xfer_total[d];
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        n0 = done_cnt[d];
        start_v[d] = 1'b1;
        count_v[d] = c;
        rng_in_v[d] = words[0];
        rng_valid_v[d] = 1'b0;
        idx = 0; k = 0; saw_ready = 1'b0;
        forever begin
            @(negedge clock);
            took = rng_valid_v[d] && rng_ready_v[d];
            saw_ready = saw_ready | rng_ready_v[d];
            if (c >= 16'd2 && k >= 1 && k <= gap)
                check($sformatf("stall_ready_no_done[dut%0d]", d), int'({rng_ready_v[d], done_v[d]}), 2);
            @(posedge clock); #1;
            k++;
            if (took) idx++;
            if (done_cnt[d] != n0) break;
            if (k > LIMIT) begin
                checks++;
                $display("FAIL timeout dut%0d: no done within %0d cycles, required one", d, LIMIT);
                reset = 1'b1;
                @(posedge clock); #1;
                reset = 1'b0;
                break;
            end
            start_v[d] = stress ? 1'($urandom_range(0, 1)) : 1'b0;
            count_v[d] = stress ? 16'($urandom) : c;
            rng_in_v[d] = words[idx < MAX_TRIES ? idx : MAX_TRIES - 1];
            rng_valid_v[d] = (k <= gap) ? 1'b0 : (hold ? 1'b1 : ($urandom_range(0, 2) != 0));
        end
        start_v[d] = 1'b0;
        rng_valid_v[d] = 1'b0;
        if (c <= 16'd1) check($sformatf("rng_ready_never[dut%0d]", d), int'(saw_ready), 0);
    endtask

    task automatic rand_words();
        for (int i = 0; i < MAX_TRIES; i++) words[i] = 16'($urandom);
    endtask

    function automatic logic [15:0] pick_count();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 3));
            1: return 16'($urandom_range(2, 70));
            2: return 16'($urandom);
            default: return 16'(16'hFFFF - 16'($urandom_range(0, 5)));
        endcase
    endfunction

    initial begin
        int xb;
        reset = 1'b1;
        start_v = '0; rng_valid_v = '0; count_v = '0; rng_in_v = '0;
        xfer_total[0] = 0; xfer_total[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_outputs[dut%0d]", d),
                  int'({addr_out_v[d], done_v[d], busy_v[d], rng_ready_v[d], err_v[d]}), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Modulo instance directed cases.
        rand_words(); words[0] = 16'd13;     run(0, 16'd2, 1'b1, 1'b0, 0);
        rand_words(); words[0] = 16'hFFFF;   run(0, 16'd1000, 1'b1, 1'b0, 0);
        rand_words();                        run(0, 16'd0, 1'b1, 1'b0, 0);
        rand_words();                        run(0, 16'd1, 1'b1, 1'b0, 0);

        // Rejection instance directed cases.
        rand_words(); words[0] = 16'd13; words[1] = 16'd3; run(1, 16'd5, 1'b1, 1'b0, 0);
        for (int i = 0; i < MAX_TRIES; i++) words[i] = 16'd7;
        run(1, 16'd5, 1'b1, 1'b0, 0);
        rand_words();                        run(1, 16'd0, 1'b1, 1'b0, 0);
        rand_words(); words[0] = 16'd2;      run(1, 16'd5, 1'b1, 1'b1, 10);
        rand_words(); words[0] = 16'd13;     run(0, 16'd2, 1'b1, 1'b1, 10);

        // Reset while the reducer is mid-way: request aborted, no done, no further RNG taken.
        @(posedge clock); #1;
        xb = xfer_total[0];
        start_v[0] = 1'b1; count_v[0] = 16'd2; rng_in_v[0] = 16'd13; rng_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("busy_before_reset", int'(busy_v[0]), 1);
        @(posedge clock);
        @(negedge clock);
        check("outputs_after_reset",
              int'({addr_out_v[0], done_v[0], busy_v[0], rng_ready_v[0], err_v[0]}), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (25) @(posedge clock);
        #1;
        check("transfers_across_reset", xfer_total[0] - xb, 1);
        rng_valid_v[0] = 1'b0;
        rand_words(); words[0] = 16'd13;     run(0, 16'd2, 1'b1, 1'b0, 0);

        // Randomised traffic on both instances.
        for (int t = 0; t < 30; t++) begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] c;
                c = pick_count();
                rand_words();
                run(d, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
        end

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard0_drained", sb0.size(), 0);
        check("scoreboard1_drained", sb1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rng_address_sel.md
Name: rng_address_sel

Overview:
Parametrised successor to the fixed-width random address picker. Maps a raw RNG word to a uniform-ish index in [0, count) for the neighbour-selection path. Supports two modes: bounded sequential modulo, or rejection sampling with modulo fallback. Consumes RNG words through a valid/ready handshake instead of a free-running input, and flags illegal counts.

Parameters:
CNT_W, 16, width of count and addr_out
RNG_W, 16, width of RNG word; must be >= CNT_W (elaboration error otherwise)
MODE, 0, 0 = modulo reduction, 1 = rejection sampling with modulo fallback
MAX_TRIES, 8, rejection attempts before fallback (MODE 1 only), >= 1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; count sampled this cycle
count  in  CNT_W  number of candidates (better neighbour count)
rng_in  in  RNG_W  random word
rng_valid  in  1  rng_in valid
rng_ready  out  1  block accepts rng_in this cycle
addr_out  out  CNT_W  selected index, held until next accepted start
done  out  1  one-cycle pulse; addr_out/err valid
busy  out  1  high from cycle after accepted start through DONE cycle
err  out  1  set with done when count == 0; cleared on next accepted start

Behaviour:
- Reset: state IDLE; addr_out=0, done=0, busy=0, rng_ready=0, err=0; tries and remainder cleared. Reset mid-operation aborts the request, emits no done, and consumes no further RNG.
- States: IDLE, DRAW, REDUCE, DONE.
- IDLE:
  - start accepted only here; start in any other state is ignored.
  - On start: latch cnt_q=count, mask_q=(smallest 2^k >= count) - 1, tries=0, err=0.
  - count==0: go DONE with addr_out=0, err=1.
  - count==1: go DONE with addr_out=0; no RNG consumed.
  - otherwise go DRAW.
- DRAW:
  - rng_ready=1. A transfer occurs when rng_valid && rng_ready; the state holds with no side effects otherwise.
  - MODE 0: load rem=0, shift register=rng_in; go REDUCE.
  - MODE 1: m = rng_in[CNT_W-1:0] & mask_q.
    - If m < cnt_q: addr_out=m, go DONE.
    - Else tries++; if tries reaches MAX_TRIES, load rng_in into the reducer and go REDUCE; else stay in DRAW.
- REDUCE:
  - Restoring shift-subtract, MSB first, one bit per cycle, exactly RNG_W cycles.
  - Per cycle: rem={rem,bit}; if rem>=cnt_q then rem-=cnt_q.
  - rem is CNT_W+1 bits wide, so no overflow.
  - After the last bit: addr_out=rem[CNT_W-1:0], go DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE and 0 in IDLE. start in the DONE cycle is ignored.
- Latency, start at cycle 0 with rng_valid held high:
  - MODE 0: rng transfer at cycle 1, done at cycle RNG_W+2.
  - MODE 1 accepted first draw: done at cycle 2.
  - count<=1: done at cycle 1.
- Result is always addr_out < cnt_q when err=0.

Decomposition:
- Package rng_addr_pkg holds:
  - state enum (IDLE/DRAW/REDUCE/DONE)
  - MODE_MODULO=0 and MODE_REJECT=1 constants
  - function pow2_mask(count) returning next-power-of-two minus 1
- One sub-module, seq_mod_reduce: the RNG_W-cycle shift-subtract remainder unit with load/busy/valid. The FSM instantiates it.

Test Plan:
- MODE 0, count=2, rng_in=13, rng_valid=1, start pulse after reset release -> done at cycle RNG_W+2 (18), addr_out=1, err=0, exactly one rng transfer.
- MODE 0, count=1000, rng_in=16'hFFFF -> addr_out=535; count=0 -> done at cycle 1, err=1, addr_out=0, rng_ready never asserted.
- MODE 1, count=5 (mask 7), rng sequence 13, 3 -> first draw rejected (13&7=5), second accepted, addr_out=3, done 1 cycle after second transfer, tries=1.
- MODE 1, MAX_TRIES=8, count=5, rng_in constant 7 -> 8 rejections, then fallback modulo, addr_out=2, 8 transfers total.
- rng_valid held low 10 cycles in DRAW -> state held, no done, rng_ready=1 throughout; start pulses while busy ignored (addr_out unchanged, single done).
- Assert reset during REDUCE -> all outputs 0 next cycle, no done; a new start with count=2 and rng_in=13 completes normally with addr_out=1.
